// File: rtl/board_test_pkg.sv
// Shared encodings for the UPduino board-test pattern generator: pattern
// modes and RGB drive constants (the RGB LED is active-low).
package board_test_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_WALK    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_LAMP    = 2'd3
  } mode_e;

  localparam logic [2:0] RGB_OFF    = 3'b111;
  localparam logic [2:0] RGB_ALL_ON = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap
// cycle combinationally so the caller can register it with the pattern update.
module tick_gen #(
  parameter int PRESCALE = 1_500_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_pcnt;
  logic          w_last;

  assign w_last = (r_pcnt == LAST);
  assign tick   = en && w_last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= w_last ? '0 : r_pcnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Board-test LED pattern generator: count, bouncing walk, PWM breathe and
// lamp test on NUM_DBG active-high LEDs plus the active-low RGB LED.
module led_pattern_gen
  import board_test_pkg::*;
#(
  parameter int PRESCALE     = 1_500_000,
  parameter int NUM_DBG      = 4,
  parameter int PWM_W        = 8,
  parameter int RGB_DUTY     = 16,
  parameter int BREATHE_STEP = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [1:0]         MODE,
  input  logic               PAUSE,
  output logic [NUM_DBG-1:0] DBG,
  output logic [2:0]         RGB,
  output logic               TICK
);

  localparam int POS_W    = (NUM_DBG > 1) ? $clog2(NUM_DBG) : 1;
  localparam int DUTY_MAX = 2**PWM_W - 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DBG - 1);

  logic [1:0]         r_mode_s1;
  mode_e              r_mode_s2, r_mode_prev;
  logic               r_pause_s1, r_pause_s2;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic [NUM_DBG-1:0] r_step_cnt;
  logic [2:0]         r_color;
  logic [POS_W-1:0]   r_pos;
  logic               r_pos_up;
  logic [PWM_W-1:0]   r_duty;
  logic               r_duty_up;
  logic [NUM_DBG-1:0] r_dbg;
  logic [2:0]         r_rgb;
  logic               r_tick;

  logic               w_en, w_step, w_mode_chg;
  logic [NUM_DBG-1:0] w_step_cnt_nxt;
  logic [2:0]         w_color_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_pos_up_nxt;
  logic [PWM_W-1:0]   w_duty_nxt;
  logic               w_duty_up_nxt;
  logic [NUM_DBG-1:0] w_dbg_nxt;
  logic [2:0]         w_rgb_nxt;

  assign w_en       = !r_pause_s2;
  assign w_mode_chg = (r_mode_s2 != r_mode_prev);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (w_en),
    .tick (w_step)
  );

  // NOTE: every signal driven here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_step_cnt_nxt = r_step_cnt;
    w_color_nxt    = r_color;
    w_pos_nxt      = r_pos;
    w_pos_up_nxt   = r_pos_up;
    w_duty_nxt     = r_duty;
    w_duty_up_nxt  = r_duty_up;

    if (w_step) begin
      w_step_cnt_nxt = r_step_cnt + NUM_DBG'(1);
      w_color_nxt    = r_color + 3'd1;

      // Bounce between the ends without dwelling; a single LED never moves.
      if (NUM_DBG > 1) begin
        if (r_pos_up) begin
          if (r_pos == POS_LAST) begin
            w_pos_nxt    = r_pos - POS_W'(1);
            w_pos_up_nxt = 1'b0;
          end else begin
            w_pos_nxt = r_pos + POS_W'(1);
          end
        end else if (r_pos == '0) begin
          w_pos_nxt    = r_pos + POS_W'(1);
          w_pos_up_nxt = 1'b1;
        end else begin
          w_pos_nxt = r_pos - POS_W'(1);
        end
      end

      if (r_duty_up) begin
        if (int'(r_duty) + BREATHE_STEP >= DUTY_MAX) begin
          w_duty_nxt    = '1;
          w_duty_up_nxt = 1'b0;
        end else begin
          w_duty_nxt = r_duty + PWM_W'(BREATHE_STEP);
        end
      end else if (int'(r_duty) <= BREATHE_STEP) begin
        w_duty_nxt    = '0;
        w_duty_up_nxt = 1'b1;
      end else begin
        w_duty_nxt = r_duty - PWM_W'(BREATHE_STEP);
      end
    end

    // A mode switch restarts walk and breathe even if a step lands together.
    if (w_mode_chg) begin
      w_pos_nxt     = '0;
      w_pos_up_nxt  = 1'b1;
      w_duty_nxt    = '0;
      w_duty_up_nxt = 1'b1;
    end
  end

  // Outputs are built from next-state values so they change with TICK.
  always_comb begin
    w_dbg_nxt = '0;
    w_rgb_nxt = (int'(r_pwm_cnt) < RGB_DUTY) ? ~w_color_nxt : RGB_OFF;
    case (r_mode_s2)
      MODE_COUNT:   w_dbg_nxt = w_step_cnt_nxt;
      MODE_WALK:    w_dbg_nxt = NUM_DBG'(1) << w_pos_nxt;
      MODE_BREATHE: w_dbg_nxt = {NUM_DBG{r_pwm_cnt < w_duty_nxt}};
      MODE_LAMP: begin
        w_dbg_nxt = '1;
        w_rgb_nxt = RGB_ALL_ON;
      end
      default:      w_dbg_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode_s1   <= '0;
      r_mode_s2   <= MODE_COUNT;
      r_mode_prev <= MODE_COUNT;
      r_pause_s1  <= 1'b0;
      r_pause_s2  <= 1'b0;
      r_pwm_cnt   <= '0;
      r_step_cnt  <= '0;
      r_color     <= '0;
      r_pos       <= '0;
      r_pos_up    <= 1'b1;
      r_duty      <= '0;
      r_duty_up   <= 1'b1;
      r_dbg       <= '0;
      r_rgb       <= RGB_OFF;
      r_tick      <= 1'b0;
    end else begin
      r_mode_s1   <= MODE;
      r_mode_s2   <= mode_e'(r_mode_s1);
      r_mode_prev <= r_mode_s2;
      r_pause_s1  <= PAUSE;
      r_pause_s2  <= r_pause_s1;
      r_pwm_cnt   <= r_pwm_cnt + PWM_W'(1);
      r_step_cnt  <= w_step_cnt_nxt;
      r_color     <= w_color_nxt;
      r_pos       <= w_pos_nxt;
      r_pos_up    <= w_pos_up_nxt;
      r_duty      <= w_duty_nxt;
      r_duty_up   <= w_duty_up_nxt;
      r_dbg       <= w_dbg_nxt;
      r_rgb       <= w_rgb_nxt;
      r_tick      <= w_step;
    end
  end

  assign DBG  = r_dbg;
  assign RGB  = r_rgb;
  assign TICK = r_tick;

endmodule
